// File: rtl/psum_accumulator.sv
// Partial-sum accumulation stage: merges MAC beats with stored partial sums (saturating, 8 lanes)
// and sequences the output buffer's pointer reset, read strobe and write strobe.
module psum_accumulator #(
  parameter int unsigned MAC_OUTPUT_WIDTH = 36,
  parameter int unsigned ADD_DELAY        = 3
) (
  input  logic                          system_clk,
  input  logic                          rst_n,
  input  logic                          pass_start,
  input  logic                          pass_first,
  input  logic [14:0]                   pass_len,
  input  logic [8*MAC_OUTPUT_WIDTH-1:0] mac_data,
  input  logic                          mac_valid,
  output logic                          refresh_req,
  output logic                          adder_pulse,
  input  logic [8*MAC_OUTPUT_WIDTH-1:0] adder_feature,
  output logic [8*MAC_OUTPUT_WIDTH-1:0] feature_in,
  output logic                          feature_valid,
  output logic                          busy,
  output logic                          pass_done,
  output logic                          sat_flag
);

  localparam int unsigned W  = MAC_OUTPUT_WIDTH;
  localparam int unsigned BW = 8 * W;
  localparam logic [W-1:0] MaxVal = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StClear, StAccum, StDrain} state_e;

  state_e state_q, state_d;

  logic                          first_q;
  logic [14:0]                   len_q, cnt_q;
  logic                          start, accept, last_beat, pipe_empty;
  logic [ADD_DELAY-1:0]          vld_q, vld_d;
  logic [ADD_DELAY-1:0][BW-1:0]  dat_q, dat_d;
  logic [BW-1:0]                 sum;
  logic                          clamp;
  logic [W-1:0]                  lane_a, lane_b;
  logic [W:0]                    lane_s;

  assign start      = (state_q == StIdle) && pass_start;
  assign last_beat  = (cnt_q + 15'd1) == len_q;
  // A pass is finished only once the final registered write has left feature_in.
  assign pipe_empty = (vld_q == '0) && !feature_valid;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pass_start) state_d = StClear;
      StClear: state_d = (len_q == '0) ? StDrain : StAccum;
      StAccum: if (mac_valid && last_beat) state_d = StDrain;
      StDrain: if (pipe_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    refresh_req = (state_q == StClear);
    busy        = (state_q != StIdle);
    accept      = (state_q == StAccum) && mac_valid;
    adder_pulse = accept && !first_q;
    pass_done   = (state_q == StDrain) && pipe_empty;
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      first_q <= pass_first;
      len_q   <= pass_len;
      cnt_q   <= '0;
    end else if (accept) begin
      cnt_q   <= cnt_q + 15'd1;
    end
  end

  // Delay line matches the buffer read latency so the stored sum lines up with its beat.
  always_comb begin
    vld_d    = '0;
    dat_d    = '0;
    vld_d[0] = accept;
    dat_d[0] = mac_data;
    for (int unsigned i = 1; i < ADD_DELAY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_comb begin
    sum    = '0;
    clamp  = 1'b0;
    lane_a = '0;
    lane_b = '0;
    lane_s = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      lane_a = dat_q[ADD_DELAY-1][k*W +: W];
      lane_b = first_q ? '0 : adder_feature[k*W +: W];
      lane_s = {lane_a[W-1], lane_a} + {lane_b[W-1], lane_b};
      // Top two bits disagree only when the W-bit signed result overflowed.
      if (lane_s[W] != lane_s[W-1]) begin
        clamp            = 1'b1;
        sum[k*W +: W]    = lane_s[W] ? MinVal : MaxVal;
      end else begin
        sum[k*W +: W]    = lane_s[W-1:0];
      end
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q         <= '0;
      dat_q         <= '0;
      feature_in    <= '0;
      feature_valid <= 1'b0;
      sat_flag      <= 1'b0;
    end else begin
      vld_q         <= vld_d;
      dat_q         <= dat_d;
      feature_valid <= vld_q[ADD_DELAY-1];
      if (vld_q[ADD_DELAY-1]) feature_in <= sum;
      if (start)                                 sat_flag <= 1'b0;
      else if (vld_q[ADD_DELAY-1] && clamp)      sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: buffer model with fixed read latency, event logs per cycle,
// a table of saturation vectors and hand-written multi-cycle sequences.
module tb_psum_accumulator;

  localparam int W  = 36;
  localparam int D  = 3;
  localparam int BW = 8 * W;
  localparam longint LMax = 64'sd34359738367;
  localparam longint LMin = -64'sd34359738368;
  localparam logic [BW-1:0] Junk = {8{36'h5_A5A5_A5A5}};

  logic          system_clk = 1'b0;
  logic          rst_n      = 1'b0;
  logic          pass_start = 1'b0;
  logic          pass_first = 1'b0;
  logic [14:0]   pass_len   = '0;
  logic [BW-1:0] mac_data   = '0;
  logic          mac_valid  = 1'b0;
  logic [BW-1:0] adder_feature = Junk;
  logic          refresh_req, adder_pulse, feature_valid, busy, pass_done, sat_flag;
  logic [BW-1:0] feature_in;

  psum_accumulator #(.MAC_OUTPUT_WIDTH(W), .ADD_DELAY(D)) dut (
    .system_clk    (system_clk),
    .rst_n         (rst_n),
    .pass_start    (pass_start),
    .pass_first    (pass_first),
    .pass_len      (pass_len),
    .mac_data      (mac_data),
    .mac_valid     (mac_valid),
    .refresh_req   (refresh_req),
    .adder_pulse   (adder_pulse),
    .adder_feature (adder_feature),
    .feature_in    (feature_in),
    .feature_valid (feature_valid),
    .busy          (busy),
    .pass_done     (pass_done),
    .sat_flag      (sat_flag)
  );

  always #5 system_clk = ~system_clk;

  int            cyc;
  int            n_chk, n_pass;
  int            wr_cyc[$], pulse_cyc[$], ref_cyc[$], done_cyc[$];
  logic [BW-1:0] wr_dat[$];
  bit            busy_log[int];
  bit            sat_log[int];
  bit            last_busy;
  logic [BW-1:0] mem[16];
  logic [BW-1:0] rd_pipe[D];
  int            ptr;

  typedef struct {
    int     ln;
    bit     first;
    longint mac;
    longint fb;
    longint exp;
    bit     sat;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [BW-1:0] lane(int k, longint v);
    logic [BW-1:0] b = '0;
    b[k*W +: W] = v[W-1:0];
    return b;
  endfunction

  function automatic int qat(int q[$], int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [BW-1:0] dat_at(int i);
    if (i < wr_dat.size()) return wr_dat[i];
    return 'x;
  endfunction

  function automatic int blog(int c);
    if (busy_log.exists(c)) return int'(busy_log[c]);
    return -1;
  endfunction

  task automatic chk_i(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_v(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Sample the current cycle at negedge, then advance and update the buffer model.
  task automatic step();
    logic p, r;
    @(negedge system_clk);
    p = adder_pulse;
    r = refresh_req;
    if (feature_valid) begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(feature_in);
    end
    if (p) pulse_cyc.push_back(cyc);
    if (r) ref_cyc.push_back(cyc);
    if (pass_done) done_cyc.push_back(cyc);
    busy_log[cyc] = busy;
    sat_log[cyc]  = sat_flag;
    last_busy     = busy;
    @(posedge system_clk);
    #1;
    cyc++;
    for (int i = D - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    rd_pipe[0] = p ? mem[ptr] : Junk;
    if (p) ptr = (ptr + 1) % 16;
    if (r) ptr = 0;
    adder_feature = rd_pipe[D-1];
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_dat.delete(); pulse_cyc.delete(); ref_cyc.delete(); done_cyc.delete();
  endtask

  task automatic idle(int n);
    mac_valid = 1'b0;
    mac_data  = Junk;
    repeat (n) step();
  endtask

  task automatic beat(logic [BW-1:0] d);
    mac_data  = d;
    mac_valid = 1'b1;
    step();
    mac_valid = 1'b0;
    mac_data  = Junk;
  endtask

  // pass_first/pass_len are scrambled afterwards to show they were latched.
  task automatic start_pass(bit first, int len, output int t0);
    pass_start = 1'b1;
    pass_first = first;
    pass_len   = 15'(len);
    t0         = cyc;
    step();
    pass_start = 1'b0;
    pass_first = ~first;
    pass_len   = '1;
  endtask

  task automatic wait_idle(int budget, string name);
    int k = 0;
    step();
    while (last_busy && k < budget) begin
      step();
      k++;
    end
    if (last_busy) begin
      n_chk++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  task automatic chk_zero(string tag);
    chk_i({tag, "_refresh"}, int'(refresh_req), 0);
    chk_i({tag, "_pulse"},   int'(adder_pulse), 0);
    chk_i({tag, "_fvalid"},  int'(feature_valid), 0);
    chk_i({tag, "_busy"},    int'(busy), 0);
    chk_i({tag, "_done"},    int'(pass_done), 0);
    chk_i({tag, "_sat"},     int'(sat_flag), 0);
    chk_v({tag, "_fin"},     feature_in, '0);
  endtask

  task automatic scen_first(string tag);
    int t0, dn;
    clear_logs();
    start_pass(1'b1, 4, t0);
    idle(1);
    for (int i = 0; i < 4; i++) beat(lane(0, i + 1));
    wait_idle(40, tag);
    chk_i({tag, "_ref_cnt"},  ref_cyc.size(), 1);
    chk_i({tag, "_ref_cyc"},  qat(ref_cyc, 0), t0 + 1);
    chk_i({tag, "_busy_t1"},  blog(t0 + 1), 1);
    chk_i({tag, "_pulses"},   pulse_cyc.size(), 0);
    chk_i({tag, "_wr_cnt"},   wr_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk_i($sformatf("%s_wr%0d_cyc", tag, i), qat(wr_cyc, i), t0 + 6 + i);
      chk_v($sformatf("%s_wr%0d_dat", tag, i), dat_at(i), lane(0, i + 1));
    end
    dn = qat(done_cyc, 0);
    chk_i({tag, "_done_cnt"}, done_cyc.size(), 1);
    chk_i({tag, "_done_cyc"}, dn, qat(wr_cyc, 3) + 1);
    chk_i({tag, "_idle_after"}, blog(dn + 1), 0);
  endtask

  initial begin
    int t0, a;
    for (int i = 0; i < D; i++) rd_pipe[i] = Junk;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    tbl[0] = '{7, 1'b0, LMax,     5,    LMax,       1'b1};
    tbl[1] = '{3, 1'b0, LMin,     -1,   LMin,       1'b1};
    tbl[2] = '{0, 1'b0, 100,      -30,  70,         1'b0};
    tbl[3] = '{5, 1'b0, -5,       -7,   -12,        1'b0};
    tbl[4] = '{1, 1'b0, LMin,     LMax, -1,         1'b0};
    tbl[5] = '{6, 1'b0, LMax,     LMax, LMax,       1'b1};
    tbl[6] = '{2, 1'b0, LMin,     LMin, LMin,       1'b1};
    tbl[7] = '{4, 1'b1, LMax,     5,    LMax,       1'b0};
    tbl[8] = '{0, 1'b0, LMax - 1, 1,    LMax,       1'b0};
    tbl[9] = '{0, 1'b0, LMin + 1, -1,   LMin,       1'b0};

    idle(2);
    chk_zero("in_reset");
    rst_n = 1'b1;
    idle(1);
    chk_zero("post_reset");

    scen_first("first");

    // Second pass: stored sums 10,20,30,40 come back three cycles after each pulse.
    clear_logs();
    for (int i = 0; i < 4; i++) mem[i] = lane(0, 10 * (i + 1));
    start_pass(1'b0, 4, t0);
    idle(1);
    for (int i = 0; i < 4; i++) beat(lane(0, i + 1));
    wait_idle(40, "second");
    chk_i("second_pulses", pulse_cyc.size(), 4);
    chk_i("second_wr_cnt", wr_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk_i($sformatf("second_pulse%0d_cyc", i), qat(pulse_cyc, i), t0 + 2 + i);
      chk_i($sformatf("second_wr%0d_cyc", i), qat(wr_cyc, i), t0 + 6 + i);
      chk_v($sformatf("second_wr%0d_dat", i), dat_at(i), lane(0, 11 * (i + 1)));
    end

    for (int i = 0; i < 10; i++) begin
      clear_logs();
      mem[0] = lane(tbl[i].ln, tbl[i].fb);
      start_pass(tbl[i].first, 1, t0);
      idle(1);
      beat(lane(tbl[i].ln, tbl[i].mac));
      wait_idle(30, $sformatf("vec%0d", i));
      chk_i($sformatf("vec%0d_sat_clr", i), int'(sat_log[t0 + 1]), 0);
      chk_i($sformatf("vec%0d_wr_cnt", i), wr_cyc.size(), 1);
      chk_i($sformatf("vec%0d_wr_cyc", i), qat(wr_cyc, 0), t0 + 6);
      chk_v($sformatf("vec%0d_dat", i), dat_at(0), lane(tbl[i].ln, tbl[i].exp));
      chk_i($sformatf("vec%0d_sat", i), int'(sat_flag), int'(tbl[i].sat));
    end

    // Gapped beats at a, a+2, a+7, then two extra beats that land in DRAIN.
    clear_logs();
    for (int i = 0; i < 3; i++) mem[i] = lane(0, 1000 * (i + 1)) | lane(7, -(i + 1));
    start_pass(1'b0, 3, t0);
    idle(1);
    a = t0 + 2;
    beat(lane(0, 7) | lane(7, 100));
    idle(1);
    beat(lane(0, 8) | lane(7, 100));
    idle(4);
    beat(lane(0, 9) | lane(7, 100));
    beat(lane(0, 55));
    beat(lane(0, 66));
    wait_idle(40, "gap");
    chk_i("gap_pulses", pulse_cyc.size(), 3);
    chk_i("gap_pulse2_cyc", qat(pulse_cyc, 2), a + 7);
    chk_i("gap_wr_cnt", wr_cyc.size(), 3);
    chk_i("gap_wr0_cyc", qat(wr_cyc, 0), a + 4);
    chk_i("gap_wr1_cyc", qat(wr_cyc, 1), a + 6);
    chk_i("gap_wr2_cyc", qat(wr_cyc, 2), a + 11);
    chk_v("gap_wr0_dat", dat_at(0), lane(0, 1007) | lane(7, 99));
    chk_v("gap_wr1_dat", dat_at(1), lane(0, 2008) | lane(7, 98));
    chk_v("gap_wr2_dat", dat_at(2), lane(0, 3009) | lane(7, 97));
    chk_i("gap_done_cyc", qat(done_cyc, 0), a + 12);

    // Zero-length pass.
    clear_logs();
    start_pass(1'b1, 0, t0);
    wait_idle(20, "len0");
    chk_i("len0_ref_cyc", qat(ref_cyc, 0), t0 + 1);
    chk_i("len0_done_cyc", qat(done_cyc, 0), t0 + 2);
    chk_i("len0_wr_cnt", wr_cyc.size(), 0);
    chk_i("len0_idle", blog(t0 + 3), 0);

    // Beat during CLEAR is dropped; pass_start while busy is ignored.
    clear_logs();
    start_pass(1'b1, 2, t0);
    beat(lane(0, 77));
    beat(lane(0, 5));
    pass_start = 1'b1;
    pass_first = 1'b0;
    pass_len   = 15'd5;
    beat(lane(0, 6));
    pass_start = 1'b0;
    wait_idle(40, "busy");
    chk_i("busy_ref_cnt", ref_cyc.size(), 1);
    chk_i("busy_pulses", pulse_cyc.size(), 0);
    chk_i("busy_wr_cnt", wr_cyc.size(), 2);
    chk_v("busy_wr0_dat", dat_at(0), lane(0, 5));
    chk_v("busy_wr1_dat", dat_at(1), lane(0, 6));
    chk_i("busy_wr0_cyc", qat(wr_cyc, 0), t0 + 6);
    chk_i("busy_done_cyc", qat(done_cyc, 0), t0 + 8);

    // Asynchronous reset in the middle of ACCUM with writes and saturation in flight.
    clear_logs();
    for (int i = 0; i < 6; i++) mem[i] = lane(7, 5);
    start_pass(1'b0, 6, t0);
    idle(1);
    for (int i = 0; i < 4; i++) beat(lane(7, LMax));
    mac_data  = lane(7, LMax);
    mac_valid = 1'b1;
    #1;
    chk_i("pre_rst_busy", int'(busy), 1);
    chk_i("pre_rst_fvalid", int'(feature_valid), 1);
    chk_i("pre_rst_pulse", int'(adder_pulse), 1);
    chk_i("pre_rst_sat", int'(sat_flag), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    clear_logs();
    step();
    idle(2);
    rst_n = 1'b1;
    idle(8);
    chk_i("rst_no_writes", wr_cyc.size(), 0);
    chk_i("rst_no_done", done_cyc.size(), 0);
    scen_first("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
